// File: rtl/fmamult_arb_if.sv
// Request/result bundle for the shared FMA significand multiplier.
// The requester/consumer side uses master; the arbiter uses slave.
interface fmamult_arb_if #(
  parameter int NF   = 52,
  parameter int TAGW = 3
);
  logic              FValid;
  logic              FReady;
  logic [NF:0]       FXm;
  logic [NF:0]       FYm;
  logic [TAGW-1:0]   FTag;
  logic              DValid;
  logic              DReady;
  logic [NF:0]       DXm;
  logic [NF:0]       DYm;
  logic [TAGW-1:0]   DTag;
  logic              Stall;
  logic              Flush;
  logic              PmValid;
  logic [2*NF+1:0]   Pm;
  logic              PmSrc;
  logic [TAGW-1:0]   PmTag;

  modport master (
    output FValid, FXm, FYm, FTag, DValid, DXm, DYm, DTag, Stall, Flush,
    input  FReady, DReady, PmValid, Pm, PmSrc, PmTag
  );

  modport slave (
    input  FValid, FXm, FYm, FTag, DValid, DXm, DYm, DTag, Stall, Flush,
    output FReady, DReady, PmValid, Pm, PmSrc, PmTag
  );
endinterface

// File: rtl/fmamult_arb.sv
// Round-robin arbiter sharing one pipelined significand multiplier between
// the FMA (F) and div/sqrt (D) requesters; results return with source and tag.
module fmamult_arb #(
  parameter int NF   = 52,
  parameter int LAT  = 2,
  parameter int TAGW = 3
) (
  input logic          clk,
  input logic          reset,
  fmamult_arb_if.slave bus
);
  localparam int PW = 2*NF+2;

  typedef enum logic {PRIO_F = 1'b0, PRIO_D = 1'b1} prio_t;

  prio_t           prio_q, prio_d;
  logic            f_acc, d_acc;
  logic [NF:0]     xm_p0, ym_p0;
  logic [TAGW-1:0] tag_p0;
  logic [PW-1:0]   prod_p0;

  logic            vld_p [1:LAT];
  logic [PW-1:0]   pm_p  [1:LAT];
  logic            src_p [1:LAT];
  logic [TAGW-1:0] tag_p [1:LAT];

  // Grants look only at valids and the pointer, never at our own ready.
  always_comb begin
    f_acc  = bus.FValid & ~bus.Stall & ~bus.Flush & ((prio_q == PRIO_F) | ~bus.DValid);
    d_acc  = bus.DValid & ~bus.Stall & ~bus.Flush & ((prio_q == PRIO_D) | ~bus.FValid);
    prio_d = prio_q;
    if (f_acc) begin
      prio_d = PRIO_D;
    end else if (d_acc) begin
      prio_d = PRIO_F;
    end
  end

  assign bus.FReady = f_acc;
  assign bus.DReady = d_acc;

  always_comb begin
    xm_p0   = d_acc ? bus.DXm  : bus.FXm;
    ym_p0   = d_acc ? bus.DYm  : bus.FYm;
    tag_p0  = d_acc ? bus.DTag : bus.FTag;
    prod_p0 = PW'(xm_p0) * PW'(ym_p0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= PRIO_F;
      for (int i = 1; i <= LAT; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      prio_q <= prio_d;
      if (bus.Flush) begin
        for (int i = 1; i <= LAT; i++) begin
          vld_p[i] <= 1'b0;
        end
      end else if (!bus.Stall) begin
        vld_p[1] <= f_acc | d_acc;
        for (int i = 2; i <= LAT; i++) begin
          vld_p[i] <= vld_p[i-1];
        end
      end
    end
  end

  // Stage 1 captures the product; stages 2..LAT only delay it.
  // Data is cleared on reset so the output fields read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= LAT; i++) begin
        pm_p[i]  <= '0;
        src_p[i] <= 1'b0;
        tag_p[i] <= '0;
      end
    end else if (!bus.Stall) begin
      pm_p[1]  <= prod_p0;
      src_p[1] <= d_acc;
      tag_p[1] <= tag_p0;
      for (int i = 2; i <= LAT; i++) begin
        pm_p[i]  <= pm_p[i-1];
        src_p[i] <= src_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign bus.PmValid = vld_p[LAT];
  assign bus.Pm      = pm_p[LAT];
  assign bus.PmSrc   = src_p[LAT];
  assign bus.PmTag   = tag_p[LAT];
endmodule
